// File: rtl/countdown_timer_arbiter.sv
// Round-robin sequencer that shares one countdown timer between N_REQ requesters.
// Loads the winner's value into the timer, waits for done, and returns an ack.
// A watchdog aborts a timer that never finishes and returns err instead of ack.
module countdown_timer_arbiter #(
    parameter  int unsigned GRANT_WIDTH = 2,
    parameter  int unsigned VALUE_WIDTH = 8,
    parameter  int unsigned TIMEOUT     = 300,
    localparam int unsigned N_REQ       = 2 ** GRANT_WIDTH
) (
    input  logic                         i_w_clk,
    input  logic                         i_w_reset,
    input  logic [N_REQ-1:0]             i_w_req,
    input  logic [N_REQ*VALUE_WIDTH-1:0] i_w_value,
    output logic [N_REQ-1:0]             o_w_ack,
    output logic [N_REQ-1:0]             o_w_err,
    output logic                         o_w_busy,
    output logic [GRANT_WIDTH-1:0]       o_w_grant_id,
    output logic                         o_w_timer_ready,
    output logic [VALUE_WIDTH-1:0]       o_w_timer_value,
    output logic                         o_w_timer_reset,
    input  logic                         i_w_timer_done
);

    localparam int unsigned WD_WIDTH = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        ABORT     = 3'd3,
        COMPLETE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [GRANT_WIDTH-1:0] grant_q, grant_d;
    logic [GRANT_WIDTH-1:0] last_q, last_d;
    logic [VALUE_WIDTH-1:0] value_q, value_d;
    logic [WD_WIDTH-1:0]    wd_q, wd_d;
    logic [N_REQ-1:0]       ack_q, ack_d;
    logic [N_REQ-1:0]       err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   ready_q, ready_d;

    logic                   pick_valid;
    logic [GRANT_WIDTH-1:0] pick_idx;
    logic [GRANT_WIDTH-1:0] cand;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = GRANT_WIDTH'(32'(last_q) + i);
            if (!pick_valid && i_w_req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic; pulses are computed on the transition
    // into the state that owns them so every output leaves a flop.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        value_d = value_q;
        wd_d    = wd_q;
        ack_d   = '0;
        err_d   = '0;
        ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    value_d = i_w_value[32'(pick_idx) * VALUE_WIDTH +: VALUE_WIDTH];
                    ready_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_w_timer_done) begin
                    ack_d[grant_q] = 1'b1;
                    state_d        = COMPLETE;
                end else if (wd_q == WD_WIDTH'(TIMEOUT - 1)) begin
                    state_d = ABORT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ABORT: begin
                err_d[grant_q] = 1'b1;
                state_d        = COMPLETE;
            end
            COMPLETE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GRANT_WIDTH'(N_REQ - 1);
            value_q <= '0;
            wd_q    <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            value_q <= value_d;
            wd_q    <= wd_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign o_w_ack         = ack_q;
    assign o_w_err         = err_q;
    assign o_w_busy        = busy_q;
    assign o_w_grant_id    = grant_q;
    assign o_w_timer_ready = ready_q;
    assign o_w_timer_value = value_q;
    // Timer reset is combinational so it tracks the global reset in the same cycle.
    assign o_w_timer_reset = i_w_reset | (state_q == ABORT);

endmodule
